// File: rtl/md_defs.sv
// Shared MD-unit definitions: op encoding (also used by the D-stage stall logic),
// FSM state encoding and default operation latencies.
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
  localparam int unsigned MD_CNT_W           = 4;

  // True for every op the stall unit must treat as MD-class (code 7 is not one).
  function automatic logic is_md_class(input logic [2:0] op);
    return (op != MD_NONE) && (op <= MD_MTLO);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath for MULT/MULTU/DIV/DIVU.
// Produces the HI/LO pair for the requested op and flags a zero divisor.
module md_arith
  import md_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_by_zero
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic               min_by_neg1;
  logic        [31:0] div_b;
  logic signed [31:0] squot;
  logic signed [31:0] srem;
  logic        [31:0] uquot;
  logic        [31:0] urem;

  assign sprod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uprod = {32'd0, A} * {32'd0, B};

  assign div_by_zero = (B == 32'd0) && ((op == MD_DIV) || (op == MD_DIVU));

  // Dividing by 1 instead gives the architected 0x80000000 / -1 result
  // (quotient 0x80000000, remainder 0) without a simulator overflow trap.
  assign min_by_neg1 = (op == MD_DIV) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign div_b       = ((B == 32'd0) || min_by_neg1) ? 32'd1 : B;

  assign squot = $signed(A) / $signed(div_b);
  assign srem  = $signed(A) % $signed(div_b);
  assign uquot = A / div_b;
  assign urem  = A % div_b;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    case (op)
      MD_MULT: begin
        hi_res = sprod[63:32];
        lo_res = sprod[31:0];
      end
      MD_MULTU: begin
        hi_res = uprod[63:32];
        lo_res = uprod[31:0];
      end
      MD_DIV: begin
        hi_res = srem;
        lo_res = squot;
      end
      MD_DIVU: begin
        hi_res = urem;
        lo_res = uquot;
      end
      default: begin
        hi_res = '0;
        lo_res = '0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div.sv
// E-stage multiply/divide unit owning HI/LO: result latched at issue, committed
// after a fixed MULT_CYCLES/DIV_CYCLES busy window; MTHI/MTLO write in one edge.
module mult_div
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MD_out
);

  localparam logic [MD_CNT_W-1:0] MULT_LAST = MD_CNT_W'(MULT_CYCLES - 1);
  localparam logic [MD_CNT_W-1:0] DIV_LAST  = MD_CNT_W'(DIV_CYCLES - 1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           hi_tmp_q, hi_tmp_d;
  logic [31:0]           lo_tmp_q, lo_tmp_d;

  logic [31:0]           hi_res;
  logic [31:0]           lo_res;
  logic                  div_by_zero;

  md_arith u_arith (
    .op          (md_op),
    .A           (A),
    .B           (B),
    .hi_res      (hi_res),
    .lo_res      (lo_res),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    case (state_q)
      MD_IDLE: begin
        case (md_op)
          MD_MULT, MD_MULTU: begin
            hi_tmp_d = hi_res;
            lo_tmp_d = lo_res;
            cnt_d    = MULT_LAST;
            state_d  = MD_RUN;
          end
          MD_DIV, MD_DIVU: begin
            // A zero divisor still occupies the full window; committing the
            // current HI/LO at the end leaves them unchanged.
            hi_tmp_d = div_by_zero ? hi_q : hi_res;
            lo_tmp_d = div_by_zero ? lo_q : lo_res;
            cnt_d    = DIV_LAST;
            state_d  = MD_RUN;
          end
          MD_MTHI: hi_d = A;
          MD_MTLO: lo_d = A;
          default: ;
        endcase
      end
      MD_RUN: begin
        if (cnt_q == '0) begin
          hi_d    = hi_tmp_q;
          lo_d    = lo_tmp_q;
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
    end
  end

  assign busy   = (state_q == MD_RUN);
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MD_out = hilo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div against an arithmetic reference of HI/LO.
module tb_mult_div;
  import md_defs::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        hilo_sel;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MD_out;

  int checks = 0;
  int passed = 0;
  int viol   = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  always #5 clk = ~clk;

  mult_div #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .hilo_sel (hilo_sel),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .MD_out   (MD_out)
  );

  // Protocol monitor: the stall unit must never present an MD op while busy.
  always @(posedge clk) begin
    if (!reset && busy === 1'b1 && md_op != 3'd0) viol++;
  end

  // Reference: architectural HI/LO effect of one op, from plain arithmetic.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] hi, inout logic [31:0] lo);
    longint          sp;
    longint          sr;
    longint unsigned up;
    case (op)
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); hi = sp[63:32]; lo = sp[31:0]; end
      3'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      3'd3: if (b != 0) begin
        sp = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        lo = sp[31:0];
        hi = sr[31:0];
      end
      3'd4: if (b != 0) begin lo = a / b; hi = a % b; end
      3'd5: hi = a;
      3'd6: lo = a;
      default: ;
    endcase
  endfunction

  // Issue one op (now=1: in the current cycle), check the busy window and the result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit now, input string tag);
    logic [31:0] nh, nl;
    int n;
    nh = exp_hi;
    nl = exp_lo;
    ref_md(op, a, b, nh, nl);
    n = (op == 3'd1 || op == 3'd2) ? MC : (op == 3'd3 || op == 3'd4) ? DC : 0;
    if (!now) @(negedge clk);
    md_op = op; A = a; B = b; hilo_sel = 1'($urandom_range(0, 1));
    @(negedge clk);
    md_op = MD_NONE; A = $urandom; B = $urandom;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (busy !== 1'b1 || HI !== exp_hi || LO !== exp_lo)
        $display("FAIL %s busy_cycle%0d: busy=%b HI=%h LO=%h, want busy=1 HI=%h LO=%h",
                 tag, i + 1, busy, HI, LO, exp_hi, exp_lo);
      else passed++;
      @(negedge clk);
    end
    exp_hi = nh;
    exp_lo = nl;
    checks++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo || MD_out !== (hilo_sel ? exp_hi : exp_lo))
      $display("FAIL %s result: busy=%b HI=%h LO=%h MD_out=%h (sel=%b), want busy=0 HI=%h LO=%h",
               tag, busy, HI, LO, MD_out, hilo_sel, exp_hi, exp_lo);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1; md_op = MD_NONE; A = '0; B = '0; hilo_sel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MD_out !== 32'd0)
      $display("FAIL reset_state: busy=%b HI=%h LO=%h MD_out=%h, want all 0", busy, HI, LO, MD_out);
    else passed++;
  endtask

  task automatic test_mult;
    run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, 0, "mult_neg3x7");
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB)
      $display("FAIL mult_neg3x7_const: HI=%h LO=%h, want FFFFFFFF FFFFFFEB", HI, LO);
    else passed++;
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0, "multu_max_x2");
    checks++;
    if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE)
      $display("FAIL multu_const: HI=%h LO=%h, want 00000001 FFFFFFFE", HI, LO);
    else passed++;
  endtask

  task automatic test_div;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7_2");
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD)
      $display("FAIL div_neg7_2_const: HI=%h LO=%h, want FFFFFFFF FFFFFFFD", HI, LO);
    else passed++;
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_min_neg1");
    checks++;
    if (HI !== 32'd0 || LO !== 32'h8000_0000)
      $display("FAIL div_min_neg1_const: HI=%h LO=%h, want 00000000 80000000", HI, LO);
    else passed++;
    run_op(MD_DIVU, 32'hFFFF_FFF9, 32'd2, 0, "divu_big_2");
  endtask

  task automatic test_mthi_mtlo_div0;
    run_op(MD_MTHI, 32'h1111_1111, 32'd0, 0, "mthi");
    run_op(MD_MTLO, 32'h2222_2222, 32'd0, 1, "mtlo");
    for (int s = 0; s < 2; s++) begin
      hilo_sel = 1'(s);
      #1;
      checks++;
      if (MD_out !== (s == 1 ? 32'h1111_1111 : 32'h2222_2222))
        $display("FAIL md_out_sel%0d: MD_out=%h, want %h", s, MD_out, s == 1 ? 32'h1111_1111 : 32'h2222_2222);
      else passed++;
    end
    run_op(MD_DIVU, 32'd7, 32'd0, 0, "divu_by_zero");
    run_op(MD_DIV, 32'hFFFF_FF00, 32'd0, 0, "div_by_zero");
    checks++;
    if (HI !== 32'h1111_1111 || LO !== 32'h2222_2222)
      $display("FAIL div0_unchanged: HI=%h LO=%h, want 11111111 22222222", HI, LO);
    else passed++;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk); md_op = MD_DIV; A = 32'd100; B = 32'd7;
    @(negedge clk); md_op = MD_NONE;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) $display("FAIL reset_mid_busy3: busy=%b, want 1", busy);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    for (int i = 0; i < DC; i++) begin
      checks++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
        $display("FAIL reset_mid_abort%0d: busy=%b HI=%h LO=%h, want 0 0 0", i, busy, HI, LO);
      else passed++;
      @(negedge clk);
    end
    run_op(MD_MULT, 32'd6, 32'hFFFF_FFF9, 0, "mult_after_reset");
  endtask

  task automatic test_protocol_violation;
    int v0;
    v0 = viol;
    run_op(MD_MTHI, 32'd0, 32'd0, 0, "clr_hi");
    run_op(MD_MTLO, 32'd0, 32'd0, 1, "clr_lo");
    @(negedge clk); md_op = MD_MULT; A = 32'd3; B = 32'd4;
    @(negedge clk); md_op = MD_MTLO; A = 32'h0000_DEAD;
    @(negedge clk); md_op = MD_DIVU; A = 32'd9; B = 32'd3;
    @(negedge clk); md_op = MD_NONE;
    for (int i = 0; i < MC - 2; i++) begin
      checks++;
      if (busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0)
        $display("FAIL ignore_busy%0d: busy=%b HI=%h LO=%h, want 1 0 0", i + 3, busy, HI, LO);
      else passed++;
      @(negedge clk);
    end
    exp_hi = 32'd0; exp_lo = 32'd12;
    checks++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo)
      $display("FAIL ignore_result: busy=%b HI=%h LO=%h, want 0 00000000 0000000c", busy, HI, LO);
    else passed++;
    checks++;
    if (viol - v0 !== 2) $display("FAIL protocol_flag: flagged=%0d, want 2", viol - v0);
    else passed++;
  endtask

  task automatic test_back_to_back;
    run_op(MD_MULTU, 32'hDEAD_BEEF, 32'h1234_5678, 0, "b2b_multu");
    run_op(MD_DIVU, 32'hDEAD_BEEF, 32'h0000_1234, 1, "b2b_divu");
    run_op(MD_MTHI, 32'hCAFE_F00D, 32'd0, 1, "b2b_mthi");
    run_op(MD_DIV, 32'h8765_4321, 32'hFFFF_FF10, 1, "b2b_div");
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [31:0] corners [4];
    corners[0] = 32'h8000_0000; corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'd0;         corners[3] = 32'd1;
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op(op, a, b, bit'($urandom_range(0, 1)), $sformatf("rand%0d_op%0d", k, op));
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo_div0();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    test_protocol_violation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
